inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//   Fetch stage feeding the pipelined machine's decode pipeline register.
//   - Owns the fetch PC and drives the word address of the combinational
//     instruction memory.
//   - Buffers fetched {PC+4, instruction} pairs in a DEPTH-entry FIFO, so
//     decode stalls (load-use) do not throttle memory fetch.
//   - Flushes on a taken branch redirect.
// PARAMETERS
//   DEPTH     4              FIFO entries; power of two, >= 2
//   RESET_PC  30'h100000     fetch word address (PC[31:2]) after reset
// PORTS
//   clk              input   1   clock; all state updates on rising edge
//   reset            input   1   synchronous, active-high reset
//   imem_addr        output  30  word address to instruction memory (= fetch PC[31:2])
//   imem_data        input   32  instruction at imem_addr, combinational
//   imem_ready       input   1   imem_data valid this cycle
//   redirect         input   1   taken branch (BEQ & zero) from execute
//   redirect_target  input   30  branch target word address
//   out_ready        input   1   decode accepts entry (= ~stall)
//   out_valid        output  1   head entry valid
//   out_inst         output  32  head instruction; 32'h0 (nop) when !out_valid
//   out_pc_plus4     output  30  head PC[31:2]+1; 30'h0 when !out_valid
//   count            output  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   Reset (sampled on rising edge, highest priority):
//     fetch PC = RESET_PC; count = 0; rd/wr pointers = 0.
//     Outputs: out_valid=0, out_inst=0, out_pc_plus4=0.
//   Per-cycle qualifiers:
//     pop  = out_valid & out_ready
//     push = imem_ready & ~redirect & (count < DEPTH | pop)
//   Datapath and ordering:
//     - imem_addr is always the fetch PC.
//     - Push writes {PC+1, imem_data} at wr_ptr; fetch PC <= PC+1 (30-bit wrap).
//     - Pop advances rd_ptr.
//     - count <= count + push - pop.
//     - Pointers wrap modulo DEPTH.
//   Latency:
//     - 1 cycle fetch-to-head. Entry pushed in cycle N is visible at out_* in
//       N+1 when the FIFO was empty.
//     - No combinational bypass from imem_data to out_*.
//   Full (count==DEPTH):
//     - Push only when pop is true the same cycle; count unchanged.
//     - Otherwise fetch PC holds.
//   Empty:
//     - out_valid=0; out_ready ignored; out_inst/out_pc_plus4 forced to 0.
//   Redirect (priority below reset, above push/pop):
//     - Next cycle: count=0, pointers=0, fetch PC=redirect_target.
//     - imem_data this cycle is discarded.
//     - Pop in the redirect cycle is still taken by decode; the entry is then
//       flushed.
//   imem_ready=0:
//     - No push; fetch PC holds; pop proceeds normally.
//   out_* are driven from FIFO storage and count only, never from inputs.
//   Head contents stay stable while out_valid & ~out_ready.
// TESTING
//   1. Reset: reset=1 for 2 cycles, imem_ready=1.
//      -> cycle after deassert: imem_addr=30'h100000, out_valid=0.
//      -> next cycle: out_valid=1, out_pc_plus4=30'h100001.
//   2. Stream: out_ready=1, imem_ready=1, sequential instructions.
//      -> one pop per cycle in address order.
//      -> count steady at 1; imem_addr increments by 1 each cycle.
//   3. Stall fill: out_ready=0 for 6 cycles.
//      -> count saturates at 4 and imem_addr holds.
//      -> on out_ready=1, the 4 entries drain in order and fetch resumes the
//         same cycle; count holds at 4 while full and streaming.
//   4. Redirect: with count=3, redirect=1, redirect_target=30'h100040.
//      -> next cycle: count=0, out_valid=0, imem_addr=30'h100040.
//      -> following cycle: out_pc_plus4=30'h100041.
//   5. Precedence: reset=1 together with redirect=1.
//      -> imem_addr=RESET_PC; reset wins.
//   6. Memory wait: imem_ready toggles 1,0,0,1.
//      -> pushes occur only on ready cycles; no duplicated or skipped address.
//      -> out_inst=0 whenever out_valid=0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, drives the instruction-memory word address
// and buffers {PC+1, instruction} pairs in a small FIFO ahead of decode.
// A taken-branch redirect flushes the FIFO and reloads the fetch PC.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h100000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [29:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     imem_ready,
  input  logic                     redirect,
  input  logic [29:0]              redirect_target,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [29:0]              out_pc_plus4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Architectural state
  logic [29:0]   pc_q, pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage: [61:32] = PC[31:2]+1, [31:0] = instruction
  logic [61:0]   mem_q [DEPTH];
  logic [61:0]   head;

  logic          full;
  logic          pop;
  logic          push;

  // Handshake qualifiers; outputs come only from storage and count
  always_comb begin
    full      = (count_q == FULL_COUNT);
    out_valid = (count_q != '0);
    pop       = out_valid & out_ready;
    // A full FIFO still accepts a fetch when the head leaves this cycle
    push      = imem_ready & ~redirect & (~full | pop);
    head      = mem_q[rd_ptr_q];
    imem_addr = pc_q;
    count     = count_q;
    // Empty FIFO presents a nop with a zero PC so decode sees clean bubbles
    out_inst     = out_valid ? head[31:0]  : 32'h0;
    out_pc_plus4 = out_valid ? head[61:32] : 30'h0;
  end

  // Next-state: redirect flushes everything, otherwise push/pop independently
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      // The head popped this cycle (if any) is still consumed by decode;
      // everything behind it is younger than the branch and is discarded.
      pc_d     = redirect_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 30'd1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= {pc_q + 30'd1, imem_data};
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue with a queue-based reference model
// and a scoreboard monitor that checks every entry decode accepts.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [29:0] RESET_PC = 30'h100000;

  logic        clk;
  logic        reset;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        redirect;
  logic [29:0] redirect_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [29:0] out_pc_plus4;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  // Reference model: fetch PC plus an ordered queue of buffered entries
  logic [29:0] model_pc;
  logic [61:0] model_q[$];
  logic [61:0] exp_q[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .imem_ready(imem_ready),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_inst(out_inst),
    .out_pc_plus4(out_pc_plus4),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: distinct word per address
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check visible state, apply inputs, advance the model
  task automatic cycle(input bit rst, input bit rdy, input bit rdir,
                       input logic [29:0] tgt, input bit ordy);
    bit pop_m, push_m;
    logic [29:0] pc_next;
    @(negedge clk);
    check("imem_addr", 64'(imem_addr), 64'(model_pc));
    check("count", 64'(count), 64'(model_q.size()));
    check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    if (model_q.size() == 0) begin
      check("empty_inst", 64'(out_inst), 64'h0);
      check("empty_pc4", 64'(out_pc_plus4), 64'h0);
    end
    reset           = rst;
    imem_ready      = rdy;
    redirect        = rdir;
    redirect_target = tgt;
    out_ready       = ordy;
    pop_m  = (model_q.size() != 0) && ordy;
    push_m = rdy && !rdir && ((model_q.size() < DEPTH) || pop_m);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (rdir) begin
      model_q.delete();
      exp_q.delete();
      model_pc = tgt;
    end else begin
      if (pop_m) void'(model_q.pop_front());
      if (push_m) begin
        pc_next = model_pc + 30'd1;
        model_q.push_back({pc_next, mem_word(model_pc)});
        exp_q.push_back({pc_next, mem_word(model_pc)});
        model_pc = pc_next;
      end
    end
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expectation
  initial begin
    logic [61:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop actual=%0h required=none at %0t", out_pc_plus4, $time);
        end else begin
          e = exp_q.pop_front();
          check("head_pc4", 64'(out_pc_plus4), 64'(e[61:32]));
          check("head_inst", 64'(out_inst), 64'(e[31:0]));
          $display("[TB] pop pc4=%h inst=%h", out_pc_plus4, out_inst);
        end
      end
    end
  end

  initial begin
    logic [29:0] tgt;
    reset = 1'b1; imem_ready = 1'b1; redirect = 1'b0;
    redirect_target = '0; out_ready = 1'b0;
    model_pc = RESET_PC;
    // Reset for two cycles; the second also asserts redirect, reset must win
    cycle(1, 1, 0, 30'h0, 0);
    cycle(1, 1, 1, 30'h2345, 0);
    // Streaming
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 30'h0, 1);
    // Stall fill then drain, including full-and-streaming cycles
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 30'h0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 30'h0, 1);
    // Drop to three entries, then redirect
    cycle(0, 0, 0, 30'h0, 1);
    cycle(0, 1, 1, 30'h100040, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 30'h0, 1);
    // Memory wait pattern
    cycle(0, 1, 0, 30'h0, 1);
    cycle(0, 0, 0, 30'h0, 1);
    cycle(0, 0, 0, 30'h0, 1);
    cycle(0, 1, 0, 30'h0, 1);
    // Redirect near the top of the address space to exercise PC wrap
    cycle(0, 1, 1, 30'h3FFFFFFE, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 30'h0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFD : 30'($urandom);
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0),
            tgt,
            ($urandom_range(0, 9) < 6));
    end
    cycle(0, 0, 0, 30'h0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
